// File: rtl/tconv_row_mult.sv
// tconv_row_mult: multiplies a feature row by a kernel row and emits one column strobe per cycle
module tconv_row_mult #(
    parameter int BIT_WIDTH     = 8,
    parameter int N_COL_FEATURE = 8,
    parameter int N_COL_KERNEL  = 5,
    parameter int N_PIX_IN      = N_COL_FEATURE*N_COL_KERNEL,
    parameter int STRB_WIDTH    = 2*BIT_WIDTH*N_PIX_IN/4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                kernel_load,
    input  logic [BIT_WIDTH*N_COL_KERNEL-1:0]   kernel_row,
    input  logic                                feature_valid,
    input  logic [BIT_WIDTH*N_COL_FEATURE-1:0]  feature_row,
    output logic                                feature_ready,
    input  logic                                stall,
    output logic                                en_shift,
    output logic [STRB_WIDTH-1:0]               data_strobe,
    output logic [2*BIT_WIDTH*N_PIX_IN-1:0]     data_out,
    output logic                                row_done,
    output logic [15:0]                         row_cnt
);
    localparam int PW = 2*BIT_WIDTH;
    localparam int CW = N_COL_FEATURE > 1 ? $clog2(N_COL_FEATURE) : 1;
    localparam logic [CW-1:0] LAST = CW'(N_COL_FEATURE-1);
    typedef enum logic {IDLE, EMIT} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [BIT_WIDTH*N_COL_KERNEL-1:0] kern_q, kern_d;
    logic [PW*N_PIX_IN-1:0] data_q, data_d, prod;
    logic row_done_q, row_done_d;
    logic [15:0] row_cnt_q, row_cnt_d;
    logic accept;
    function automatic logic [PW-1:0] smul(input logic [BIT_WIDTH-1:0] a, input logic [BIT_WIDTH-1:0] b);
        logic signed [PW-1:0] ax, bx;
        ax = {{BIT_WIDTH{a[BIT_WIDTH-1]}}, a};
        bx = {{BIT_WIDTH{b[BIT_WIDTH-1]}}, b};
        return ax * bx;
    endfunction
    assign kern_d        = kernel_load ? kernel_row : kern_q;
    assign feature_ready = state_q == IDLE;
    assign accept        = feature_valid && feature_ready;
    assign en_shift      = state_q == EMIT && !stall;
    assign data_strobe   = en_shift ? STRB_WIDTH'(1) << col_q : '0;
    assign data_out      = data_q;
    assign row_done      = row_done_q;
    assign row_cnt       = row_cnt_q;
    // the bypassed kernel lets a coincident load apply to the row accepted on the same edge
    always_comb begin
        prod = '0;
        for (int c = 0; c < N_COL_FEATURE; c++)
            for (int k = 0; k < N_COL_KERNEL; k++)
                prod[(c*N_COL_KERNEL+k)*PW +: PW] = smul(feature_row[c*BIT_WIDTH +: BIT_WIDTH], kern_d[k*BIT_WIDTH +: BIT_WIDTH]);
    end
    always_comb begin
        state_d    = accept ? EMIT : state_q;
        col_d      = accept ? '0 : col_q;
        data_d     = accept ? prod : data_q;
        row_done_d = 1'b0;
        row_cnt_d  = row_cnt_q;
        if (en_shift) begin
            col_d      = col_q != LAST ? col_q + CW'(1) : col_q;
            state_d    = col_q != LAST ? EMIT : IDLE;
            row_done_d = col_q == LAST;
            row_cnt_d  = col_q == LAST ? row_cnt_q + 16'd1 : row_cnt_q;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            col_q      <= '0;
            kern_q     <= '0;
            data_q     <= '0;
            row_done_q <= 1'b0;
            row_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            kern_q     <= kern_d;
            data_q     <= data_d;
            row_done_q <= row_done_d;
            row_cnt_q  <= row_cnt_d;
        end
    end
endmodule

// File: doc/tconv_row_mult.md
TCONV_ROW_MULT -- requirements
Module: tconv_row_mult

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 8, operand width of feature and kernel pixels (signed two's complement).
REQ-002 SHALL have parameter N_COL_FEATURE, default 8, feature pixels per row.
REQ-003 SHALL have parameter N_COL_KERNEL, default 5, kernel taps per row.
REQ-004 SHALL have parameter N_PIX_IN, default N_COL_FEATURE*N_COL_KERNEL, product lanes per row.
REQ-005 SHALL have parameter STRB_WIDTH, default 2*BIT_WIDTH*N_PIX_IN/4, strobe bus width matching the downstream shift/accumulate stage.
REQ-006 SHALL have port clk, input, 1, single clock; all logic on the rising edge.
REQ-007 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-008 SHALL have port kernel_load, input, 1, capture kernel_row this cycle.
REQ-009 SHALL have port kernel_row, input, BIT_WIDTH*N_COL_KERNEL, tap k at bits [k*BIT_WIDTH +: BIT_WIDTH].
REQ-010 SHALL have port feature_valid, input, 1, feature_row valid.
REQ-011 SHALL have port feature_row, input, BIT_WIDTH*N_COL_FEATURE, pixel c at bits [c*BIT_WIDTH +: BIT_WIDTH].
REQ-012 SHALL have port feature_ready, output, 1, block can accept a row.
REQ-013 SHALL have port stall, input, 1, downstream busy (accumulation-finish window); pauses emission.
REQ-014 SHALL have port en_shift, output, 1, one column slot presented this cycle.
REQ-015 SHALL have port data_strobe, output, STRB_WIDTH, one-hot column select in bits [N_COL_FEATURE-1:0]; upper bits always 0.
REQ-016 SHALL have port data_out, output, 2*BIT_WIDTH*N_PIX_IN, product of pixel c and tap k at lane c*N_COL_KERNEL+k, each lane 2*BIT_WIDTH wide.
REQ-017 SHALL have port row_done, output, 1, one-cycle pulse after the last column of a row is emitted.
REQ-018 SHALL have port row_cnt, output, 16, count of completed rows.

Function
REQ-019 SHALL hold a kernel register; kernel_load=1 loads kernel_row at the edge, in any state.
REQ-020 SHALL implement FSM states IDLE and EMIT; feature_ready=1 exactly when state==IDLE.
REQ-021 SHALL accept a row on feature_valid&&feature_ready; at that edge: all N_PIX_IN products registered into data_out, column index col<=0, state<=EMIT.
REQ-022 SHALL use kernel_row (bypass) rather than the kernel register when kernel_load and accept coincide.
REQ-023 SHALL compute each lane as a full signed BIT_WIDTH x BIT_WIDTH product, sign-extended into 2*BIT_WIDTH bits, with no truncation or saturation.
REQ-024 SHALL drive en_shift = (state==EMIT) && !stall, combinationally.
REQ-025 SHALL drive data_strobe = one-hot(col) when en_shift=1, else all zeros.
REQ-026 SHALL, on an edge with en_shift=1, set col<=col+1 if col<N_COL_FEATURE-1; otherwise state<=IDLE, row_done<=1 for one cycle, and row_cnt<=row_cnt+1 (wraps 0xFFFF->0).
REQ-027 SHALL hold col and state unchanged while stall=1 in EMIT; a stall may last any number of cycles.
REQ-028 SHALL hold data_out constant from accept until the next accept, including in IDLE.
REQ-029 SHALL have a first-en_shift latency of 1 cycle after accept when stall=0; a row then occupies exactly N_COL_FEATURE non-stalled EMIT cycles.
REQ-030 SHALL ignore feature_valid in EMIT; the row is neither captured nor dropped silently (upstream holds it).
REQ-031 SHALL have back-to-back throughput of one row per N_COL_FEATURE+1 cycles: IDLE lasts one cycle when feature_valid is already high.

Reset
REQ-032 SHALL, on rst=1 at an edge, set state=IDLE, col=0, kernel register=0, data_out=0, row_done=0, row_cnt=0; en_shift=0, data_strobe=0, feature_ready=1 follow.
REQ-033 SHALL give rst priority over kernel_load, accept and emission; reset mid-EMIT abandons the row with no row_done.

Verification
REQ-034 SHALL cover basic row: kernel {1,2,3,4,5}, feature all 3, stall=0 -> en_shift for 8 consecutive cycles starting 1 cycle after accept, strobe 0x01..0x80, lane c*5+k = 3*(k+1), then row_done pulse and row_cnt=1.
REQ-035 SHALL cover signed extremes: feature -128, tap -128 -> lane 0x4000; feature -128, tap 127 -> lane 0xC080.
REQ-036 SHALL cover stall: stall=1 for 3 cycles while col=4 -> en_shift=0 and strobe=0 for those cycles, resumes at strobe 0x10, row completes after 11 EMIT cycles.
REQ-037 SHALL cover coincident kernel_load of {7,7,7,7,7} with accept of feature all 2 -> every lane =14.
REQ-038 SHALL cover reset mid-row: rst at col=5 -> next cycle data_out=0, feature_ready=1, row_cnt unchanged (0), no row_done.
REQ-039 SHALL cover back-to-back: feature_valid held high for 2 rows -> second accept 9 cycles after first, row_cnt=2.
